// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared constants and state type for the remote-player packet RX.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam logic [7:0] PKT_HEADER = 8'hA5;
   localparam int         PKT_LEN    = 6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_XH  = 3'd1,
      GET_XL  = 3'd2,
      GET_YH  = 3'd3,
      GET_YL  = 3'd4,
      GET_CHK = 3'd5
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/data_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_rx_if
//  Purpose  : FIFO-side byte stream and decoded position outputs of data_rx.
//  Revision : 1.0  initial release
// ============================================================================
interface data_rx_if;

   logic        rx_empty;
   logic [7:0]  r_data;
   logic        rd_uart;
   logic [11:0] pos_x;
   logic [11:0] pos_y;
   logic        pkt_valid;
   logic        pkt_err;

   modport slave (
      input  rx_empty, r_data,
      output rd_uart, pos_x, pos_y, pkt_valid, pkt_err
   );

   modport master (
      output rx_empty, r_data,
      input  rd_uart, pos_x, pos_y, pkt_valid, pkt_err
   );

endinterface
`default_nettype wire

// File: rtl/rx_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : rx_timeout_cnt
//  Purpose  : Inter-byte gap counter; pulses timeout on the last allowed cycle.
//  Revision : 1.0  initial release
// ============================================================================
module rx_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [C_CNT_W-1:0] r_count;

   assign timeout = enable && !clear && (r_count == C_LAST);

   // Wrapping to zero on timeout keeps the counter inside its range.
   always_ff @(posedge clk) begin
      if (rst || clear || timeout) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + C_CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_rx.sv
`default_nettype none
// ============================================================================
//  Module   : data_rx
//  Purpose  : Parses 6-byte position packets from a UART RX FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module data_rx
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   data_rx_if.slave   bus
);

   rx_state_t   r_state;
   logic [3:0]  r_x_hi;
   logic [7:0]  r_x_lo;
   logic [3:0]  r_y_hi;
   logic [7:0]  r_y_lo;
   logic [7:0]  r_chk;
   logic [11:0] r_pos_x;
   logic [11:0] r_pos_y;
   logic        r_pkt_valid;
   logic        r_pkt_err;

   logic        w_take;
   logic [7:0]  w_byte;
   logic        w_timeout;

   // The FIFO is popped whenever it has data, except during reset.
   assign w_take         = !bus.rx_empty && !rst;
   assign w_byte         = bus.r_data;
   assign bus.rd_uart    = w_take;
   assign bus.pos_x      = r_pos_x;
   assign bus.pos_y      = r_pos_y;
   assign bus.pkt_valid  = r_pkt_valid;
   assign bus.pkt_err    = r_pkt_err;

   rx_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   ((r_state == IDLE) || w_take),
      .enable  ((r_state != IDLE) && !w_take),
      .timeout (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x_hi      <= '0;
         r_x_lo      <= '0;
         r_y_hi      <= '0;
         r_y_lo      <= '0;
         r_chk       <= '0;
         r_pos_x     <= '0;
         r_pos_y     <= '0;
         r_pkt_valid <= 1'b0;
         r_pkt_err   <= 1'b0;
      end else begin
         r_pkt_valid <= 1'b0;
         r_pkt_err   <= 1'b0;
         if (w_take) begin
            case (r_state)
               IDLE: begin
                  if (w_byte == PKT_HEADER) begin
                     r_state <= GET_XH;
                  end
               end
               GET_XH: begin
                  r_x_hi  <= w_byte[3:0];
                  r_chk   <= w_byte;
                  r_state <= GET_XL;
               end
               GET_XL: begin
                  r_x_lo  <= w_byte;
                  r_chk   <= r_chk ^ w_byte;
                  r_state <= GET_YH;
               end
               GET_YH: begin
                  r_y_hi  <= w_byte[3:0];
                  r_chk   <= r_chk ^ w_byte;
                  r_state <= GET_YL;
               end
               GET_YL: begin
                  r_y_lo  <= w_byte;
                  r_chk   <= r_chk ^ w_byte;
                  r_state <= GET_CHK;
               end
               GET_CHK: begin
                  if (w_byte == r_chk) begin
                     r_pos_x     <= {r_x_hi, r_x_lo};
                     r_pos_y     <= {r_y_hi, r_y_lo};
                     r_pkt_valid <= 1'b1;
                  end else begin
                     r_pkt_err   <= 1'b1;
                  end
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end else if (w_timeout) begin
            r_pkt_err <= 1'b1;
            r_state   <= IDLE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_rx
//  Purpose  : Self-checking bench for data_rx against a packet-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_rx;
   import uart_pkg::*;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_rx_if bus ();

   data_rx #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int errors  = 0;
   bit check_en = 1'b0;

   // Packet-level reference: bytes collected so far and idle-gap length.
   logic [7:0]  q[$];
   int          gap = 0;
   logic        exp_valid = 1'b0;
   logic        exp_err   = 1'b0;
   logic [11:0] exp_x     = '0;
   logic [11:0] exp_y     = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic [7:0] sum;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (rst) begin
         q.delete();
         gap   = 0;
         exp_x = '0;
         exp_y = '0;
      end else if (!bus.rx_empty) begin
         gap = 0;
         if (q.size() != 0 || bus.r_data == PKT_HEADER) q.push_back(bus.r_data);
         if (q.size() == PKT_LEN) begin
            sum = q[1] ^ q[2] ^ q[3] ^ q[4];
            if (sum == q[5]) begin
               exp_valid = 1'b1;
               exp_x = {q[1][3:0], q[2]};
               exp_y = {q[3][3:0], q[4]};
            end else begin
               exp_err = 1'b1;
            end
            q.delete();
         end
      end else if (q.size() != 0) begin
         gap++;
         if (gap == TO) begin
            exp_err = 1'b1;
            q.delete();
            gap = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("rd_uart",   {31'd0, bus.rd_uart},   {31'd0, !bus.rx_empty && !rst});
         check("pkt_valid", {31'd0, bus.pkt_valid}, {31'd0, exp_valid});
         check("pkt_err",   {31'd0, bus.pkt_err},   {31'd0, exp_err});
         check("pos_x",     {20'd0, bus.pos_x},     {20'd0, exp_x});
         check("pos_y",     {20'd0, bus.pos_y},     {20'd0, exp_y});
      end
   end

   task automatic send(input logic [7:0] b);
      rst = 1'b0;
      bus.rx_empty = 1'b0;
      bus.r_data = b;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         rst = 1'b0;
         bus.rx_empty = 1'b1;
         bus.r_data = 8'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      bus.rx_empty = 1'($urandom);
      bus.r_data = PKT_HEADER;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_pkt(input logic [11:0] x, input logic [11:0] y,
                           input bit corrupt, input int max_gap);
      logic [7:0] b[6];
      b[0] = PKT_HEADER;
      b[1] = {4'($urandom), x[11:8]};
      b[2] = x[7:0];
      b[3] = {4'($urandom), y[11:8]};
      b[4] = y[7:0];
      b[5] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ (corrupt ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      for (int i = 0; i < 6; i++) begin
         send(b[i]);
         if (i < 5 && max_gap > 0) idle($urandom_range(0, max_gap));
      end
   endtask

   initial begin
      int m;
      rst = 1'b1;
      bus.rx_empty = 1'b0;
      bus.r_data = PKT_HEADER;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_en = 1'b1;
      check("reset pos_x", {20'd0, bus.pos_x}, 32'h0);
      check("reset pos_y", {20'd0, bus.pos_y}, 32'h0);
      check("reset valid", {31'd0, bus.pkt_valid}, 32'h0);
      check("reset rd_uart", {31'd0, bus.rd_uart}, 32'h0);

      // Good packet.
      send(8'hA5); send(8'h01); send(8'h23); send(8'h02); send(8'h34); send(8'h14);
      check("good valid", {31'd0, bus.pkt_valid}, 32'h1);
      check("good x", {20'd0, bus.pos_x}, 32'h123);
      check("good y", {20'd0, bus.pos_y}, 32'h234);
      idle(2);

      // Bad checksum.
      send(8'hA5); send(8'h01); send(8'h23); send(8'h02); send(8'h34); send(8'h15);
      check("badchk err", {31'd0, bus.pkt_err}, 32'h1);
      check("badchk x hold", {20'd0, bus.pos_x}, 32'h123);
      idle(2);

      // Garbage then packet.
      send(8'h00); send(8'hFF); send(8'h5A);
      send(8'hA5); send(8'h0F); send(8'hFF); send(8'h00); send(8'h10); send(8'hE0);
      check("garbage valid", {31'd0, bus.pkt_valid}, 32'h1);
      check("garbage x", {20'd0, bus.pos_x}, 32'hFFF);
      check("garbage y", {20'd0, bus.pos_y}, 32'h010);
      idle(2);

      // Timeout boundary.
      send(8'hA5); send(8'h01);
      idle(TO - 1);
      check("pre-timeout err", {31'd0, bus.pkt_err}, 32'h0);
      idle(1);
      check("timeout err", {31'd0, bus.pkt_err}, 32'h1);
      send(8'hA5); send(8'h00); send(8'h11); send(8'h00); send(8'h22); send(8'h33);
      check("post-timeout valid", {31'd0, bus.pkt_valid}, 32'h1);
      check("post-timeout x", {20'd0, bus.pos_x}, 32'h011);
      idle(2);

      // Reset mid-packet.
      send(8'hA5); send(8'h01); send(8'h23);
      reset_cycle();
      send(8'h02); send(8'h34); send(8'h14);
      check("rst tail valid", {31'd0, bus.pkt_valid}, 32'h0);
      check("rst pos_x", {20'd0, bus.pos_x}, 32'h0);
      send(8'hA5); send(8'h01); send(8'h23); send(8'h02); send(8'h34); send(8'h14);
      check("rst recover valid", {31'd0, bus.pkt_valid}, 32'h1);

      // Back-to-back packets, six cycles apart.
      send(8'hA5); send(8'h0A); send(8'hBC); send(8'h0D); send(8'hEF); send(8'h54);
      check("b2b first valid", {31'd0, bus.pkt_valid}, 32'h1);
      check("b2b first x", {20'd0, bus.pos_x}, 32'hABC);
      send(8'hA5); send(8'h01); send(8'h23); send(8'h02); send(8'h34); send(8'h14);
      check("b2b second valid", {31'd0, bus.pkt_valid}, 32'h1);
      check("b2b second y", {20'd0, bus.pos_y}, 32'h234);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         m = $urandom_range(0, 9);
         case (m)
            0: for (int k = 0; k < $urandom_range(1, 4); k++) send(8'($urandom));
            1: idle($urandom_range(1, 5));
            2: reset_cycle();
            3: begin
               send(PKT_HEADER);
               for (int k = 0; k < $urandom_range(0, 3); k++) send(8'($urandom));
               idle($urandom_range(TO - 2, TO + 2));
            end
            default: send_pkt(12'($urandom), 12'($urandom),
                              $urandom_range(0, 4) == 0, (m == 4) ? 2 : 0);
         endcase
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
